apb_root_router: RTL and testbench
==================================

Name: apb_root_router

Overview:
- Sits directly downstream of the FMC-to-APB bridge, on the root APB bus.
- Consumes one APB requester and fans it out to NUM_PORTS APB completers by fixed-size address windows.
- Re-times each transfer into a clean SETUP/ACCESS sequence and returns a registered response upstream.
- Guards the FMC master against hung completers with decode-error and timeout responses.

Parameters:
- NUM_PORTS, 4, number of downstream completers; 2..16.
- ADDR_WIDTH, 19, APB address width, matching the root bus.
- SEL_LSB, 12, LSB of the port-select field; each window is 2^SEL_LSB bytes.
- TIMEOUT_CYCLES, 1024, ACCESS-phase cycles before abort (only with APB_ROUTER_TIMEOUT_EN).
- Data width is fixed at 32; strobe width is fixed at 4.

Ports:
- pclk  in  1  root APB clock; sole clock.
- rst  in  1  synchronous, active-high reset.
- s_psel  in  1  upstream select.
- s_penable  in  1  upstream enable.
- s_paddr  in  ADDR_WIDTH  upstream address.
- s_pwrite  in  1  upstream write flag.
- s_pwdata  in  32  upstream write data.
- s_pstrb  in  4  upstream byte strobes.
- s_pready  out  1  one-cycle completion pulse.
- s_prdata  out  32  read data, held until the next completion.
- s_pslverr  out  1  error flag, valid with s_pready.
- m_psel  out  NUM_PORTS  one-hot completer selects.
- m_penable  out  1  shared enable.
- m_paddr  out  ADDR_WIDTH  shared address; full address, not window-relative.
- m_pwrite  out  1  shared write flag.
- m_pwdata  out  32  shared write data.
- m_pstrb  out  4  shared strobes.
- m_pready  in  NUM_PORTS  per-completer ready.
- m_prdata  in  32*NUM_PORTS  per-completer read data; port i occupies bits [32i+31:32i].
- m_pslverr  in  NUM_PORTS  per-completer error.
- err_addr  out  ADDR_WIDTH  address of the most recent errored transfer.

Behaviour:
- Reset: state IDLE. All m_* outputs, s_pready, s_pslverr, s_prdata and err_addr are 0. Timeout counter is cleared.
- A reset asserted mid-transfer aborts immediately: no response is issued, and m_psel drops on the next edge.

Transfer acceptance:
- A request is accepted only in IDLE, on an edge where s_psel && s_penable are both high.
- Upstream may raise penable before psel; only the AND of the two is meaningful.

Address decode:
- idx = s_paddr[SEL_LSB +: $clog2(NUM_PORTS)].
- The decode is valid only when s_paddr[ADDR_WIDTH-1 : SEL_LSB+$clog2(NUM_PORTS)] == 0 and idx < NUM_PORTS.

On accept:
- Latch addr, write flag, wdata, strb and idx into m_*.
- Valid decode: go to SETUP.
- Invalid decode: go to RESP with err=1 and rdata=0, without touching any m_psel.

State machine:
- SETUP: m_psel[idx]=1, m_penable=0. Next state ACCESS.
- ACCESS: m_penable=1. When m_pready[idx] is high:
  - capture m_prdata[idx] and m_pslverr[idx];
  - drop m_psel and m_penable;
  - go to RESP.
- RESP: s_pready=1 for exactly one cycle; s_prdata and s_pslverr are valid. Next state IDLE.
  - If err, err_addr <= latched address.

Latency:
- Minimum is 3 edges from the accepting edge to s_pready high (pready in the first ACCESS cycle).
- Each additional completer wait state adds one cycle.
- A decode error responds after 1 edge.

Other rules:
- Upstream drops psel/penable on the edge it sees s_pready. RESP->IDLE on that same edge prevents double acceptance.
- Writes return s_prdata=0.
- m_pready and m_pslverr from non-selected ports are ignored.

Optional Feature:
- Macro: APB_ROUTER_TIMEOUT_EN.
- Defined:
  - A counter clears on SETUP entry and increments each ACCESS cycle.
  - When it reaches TIMEOUT_CYCLES-1 without pready: drop m_psel/m_penable, go to RESP with err=1, rdata=0.
  - If pready and terminal count coincide, pready wins (normal response).
- Undefined:
  - No counter is generated; ACCESS waits indefinitely.
  - TIMEOUT_CYCLES is ignored.

Decomposition:
- Package apb_router_pkg holds:
  - state enum {IDLE, SETUP, ACCESS, RESP};
  - APB_DATA_WIDTH=32 and APB_STRB_WIDTH=4;
  - ERR_RDATA=32'h0;
  - pure function decode_port(addr) -> {valid, idx}.
- No sub-module is needed; the single module is 150-250 lines.

Test Plan (NUM_PORTS=4, SEL_LSB=12, ADDR_WIDTH=19, TIMEOUT_CYCLES=16):
- Read 0x02004; port 2 returns pready immediately with prdata 0xCAFEBABE -> m_psel=4'b0100 for 2 cycles; s_pready at edge +3; s_prdata=0xCAFEBABE, s_pslverr=0.
- Write 0x03010, pwdata 0x12345678, pstrb 4'b0011; port 3 inserts 2 wait states -> m_pwdata/m_pstrb match; s_pready at edge +5; exactly one m_psel pulse.
- Read 0x04000 (upper bits nonzero) -> no m_psel activity; s_pready at edge +1 with pslverr=1, prdata=0; err_addr=0x04000.
- With macro, port 1 never readies -> abort after 16 ACCESS cycles; pslverr=1, err_addr=0x01000. A late m_pready[1] afterwards produces no upstream pulse.
- Upstream asserts penable one cycle before psel -> acceptance on the first cycle both are high. Held request after s_pready -> no second transfer.
- rst pulsed during ACCESS -> all outputs 0 next edge. A following read to port 0 completes normally.

Source files
------------

// File: rtl/apb_router_pkg.sv
// Shared types, constants and the port-decode helper for apb_root_router.
package apb_router_pkg;

   localparam int APB_DATA_WIDTH = 32;
   localparam int APB_STRB_WIDTH = 4;
   localparam logic [APB_DATA_WIDTH-1:0] ERR_RDATA = 32'h0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   // Result of decoding an address against the port windows.
   typedef struct packed {
      logic       valid;
      logic [3:0] idx;
   } port_dec_t;

   // Port index is the field just above the window offset; everything above
   // that field must be zero and the index must name an existing port.
   function automatic port_dec_t decode_port(input logic [31:0] addr,
                                             input int unsigned num_ports,
                                             input int unsigned sel_lsb);
      int unsigned idx_w;
      logic [31:0] field;
      logic [31:0] upper;
      port_dec_t   r;
      idx_w   = (num_ports > 1) ? $clog2(num_ports) : 1;
      field   = addr >> sel_lsb;
      upper   = field >> idx_w;
      field   = field & ((32'd1 << idx_w) - 32'd1);
      r.valid = (upper == 32'd0) && (field < num_ports);
      r.idx   = field[3:0];
      return r;
   endfunction

endpackage

// File: rtl/apb_root_router.sv
// apb_root_router: one root-bus APB requester fanned out to NUM_PORTS
// completers by 2^SEL_LSB-byte windows, with a registered upstream response.
// Optional ACCESS-phase watchdog: define APB_ROUTER_TIMEOUT_EN.
module apb_root_router
   import apb_router_pkg::*;
#(
   parameter int NUM_PORTS      = 4,
   parameter int ADDR_WIDTH     = 19,
   parameter int SEL_LSB        = 12,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                                pclk,
   input  logic                                rst,
   input  logic                                s_psel,
   input  logic                                s_penable,
   input  logic [ADDR_WIDTH-1:0]               s_paddr,
   input  logic                                s_pwrite,
   input  logic [APB_DATA_WIDTH-1:0]           s_pwdata,
   input  logic [APB_STRB_WIDTH-1:0]           s_pstrb,
   output logic                                s_pready,
   output logic [APB_DATA_WIDTH-1:0]           s_prdata,
   output logic                                s_pslverr,
   output logic [NUM_PORTS-1:0]                m_psel,
   output logic                                m_penable,
   output logic [ADDR_WIDTH-1:0]               m_paddr,
   output logic                                m_pwrite,
   output logic [APB_DATA_WIDTH-1:0]           m_pwdata,
   output logic [APB_STRB_WIDTH-1:0]           m_pstrb,
   input  logic [NUM_PORTS-1:0]                m_pready,
   input  logic [APB_DATA_WIDTH*NUM_PORTS-1:0] m_prdata,
   input  logic [NUM_PORTS-1:0]                m_pslverr,
   output logic [ADDR_WIDTH-1:0]               err_addr
);

   localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   state_t                    state_q, state_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [NUM_PORTS-1:0]      m_psel_q, m_psel_d;
   logic                      m_penable_q, m_penable_d;
   logic [ADDR_WIDTH-1:0]     m_paddr_q, m_paddr_d;
   logic                      m_pwrite_q, m_pwrite_d;
   logic [APB_DATA_WIDTH-1:0] m_pwdata_q, m_pwdata_d;
   logic [APB_STRB_WIDTH-1:0] m_pstrb_q, m_pstrb_d;
   logic                      s_pready_q, s_pready_d;
   logic [APB_DATA_WIDTH-1:0] s_prdata_q, s_prdata_d;
   logic                      s_pslverr_q, s_pslverr_d;
   logic [ADDR_WIDTH-1:0]     err_addr_q, err_addr_d;

   port_dec_t                 dec;
   logic [APB_DATA_WIDTH-1:0] sel_rdata;
   logic                      timeout_hit;

   assign dec       = decode_port(32'(s_paddr), NUM_PORTS, SEL_LSB);
   assign sel_rdata = m_prdata[APB_DATA_WIDTH*idx_q +: APB_DATA_WIDTH];

`ifdef APB_ROUTER_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CNT_W-1:0] to_cnt_q;

   // Counts ACCESS cycles; held at zero everywhere else so SETUP entry clears it.
   always_ff @(posedge pclk) begin
      if (rst || state_q != ACCESS) to_cnt_q <= '0;
      else                          to_cnt_q <= to_cnt_q + 1'b1;
   end

   assign timeout_hit = (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   // Next-state and output-register logic for the transfer sequencer.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      m_psel_d    = m_psel_q;
      m_penable_d = m_penable_q;
      m_paddr_d   = m_paddr_q;
      m_pwrite_d  = m_pwrite_q;
      m_pwdata_d  = m_pwdata_q;
      m_pstrb_d   = m_pstrb_q;
      s_pready_d  = s_pready_q;
      s_prdata_d  = s_prdata_q;
      s_pslverr_d = s_pslverr_q;
      err_addr_d  = err_addr_q;
      case (state_q)
         IDLE: begin
            if (s_psel && s_penable) begin
               m_paddr_d  = s_paddr;
               m_pwrite_d = s_pwrite;
               m_pwdata_d = s_pwdata;
               m_pstrb_d  = s_pstrb;
               idx_d      = dec.idx[IDX_W-1:0];
               if (dec.valid) begin
                  m_psel_d                     = '0;
                  m_psel_d[dec.idx[IDX_W-1:0]] = 1'b1;
                  state_d                      = SETUP;
               end else begin
                  // Decode miss answers straight away; no completer sees it.
                  s_pready_d  = 1'b1;
                  s_pslverr_d = 1'b1;
                  s_prdata_d  = ERR_RDATA;
                  state_d     = RESP;
               end
            end
         end
         SETUP: begin
            m_penable_d = 1'b1;
            state_d     = ACCESS;
         end
         ACCESS: begin
            // pready is tested first so it wins over a coincident timeout.
            if (m_pready[idx_q]) begin
               s_prdata_d  = m_pwrite_q ? '0 : sel_rdata;
               s_pslverr_d = m_pslverr[idx_q];
               s_pready_d  = 1'b1;
               m_psel_d    = '0;
               m_penable_d = 1'b0;
               state_d     = RESP;
            end else if (timeout_hit) begin
               s_prdata_d  = ERR_RDATA;
               s_pslverr_d = 1'b1;
               s_pready_d  = 1'b1;
               m_psel_d    = '0;
               m_penable_d = 1'b0;
               state_d     = RESP;
            end
         end
         RESP: begin
            s_pready_d  = 1'b0;
            s_pslverr_d = 1'b0;
            if (s_pslverr_q) err_addr_d = m_paddr_q;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset clears everything, aborting any transfer.
   always_ff @(posedge pclk) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         m_psel_q    <= '0;
         m_penable_q <= 1'b0;
         m_paddr_q   <= '0;
         m_pwrite_q  <= 1'b0;
         m_pwdata_q  <= '0;
         m_pstrb_q   <= '0;
         s_pready_q  <= 1'b0;
         s_prdata_q  <= '0;
         s_pslverr_q <= 1'b0;
         err_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         m_psel_q    <= m_psel_d;
         m_penable_q <= m_penable_d;
         m_paddr_q   <= m_paddr_d;
         m_pwrite_q  <= m_pwrite_d;
         m_pwdata_q  <= m_pwdata_d;
         m_pstrb_q   <= m_pstrb_d;
         s_pready_q  <= s_pready_d;
         s_prdata_q  <= s_prdata_d;
         s_pslverr_q <= s_pslverr_d;
         err_addr_q  <= err_addr_d;
      end
   end

   assign m_psel    = m_psel_q;
   assign m_penable = m_penable_q;
   assign m_paddr   = m_paddr_q;
   assign m_pwrite  = m_pwrite_q;
   assign m_pwdata  = m_pwdata_q;
   assign m_pstrb   = m_pstrb_q;
   assign s_pready  = s_pready_q;
   assign s_prdata  = s_prdata_q;
   assign s_pslverr = s_pslverr_q;
   assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_apb_root_router.sv
// Testbench for apb_root_router (NUM_PORTS=4, SEL_LSB=12, ADDR_WIDTH=19,
// TIMEOUT_CYCLES=16). Build with APB_ROUTER_TIMEOUT_EN to cover the watchdog.
module tb_apb_root_router;

   localparam int NP = 4;
   localparam int AW = 19;
   localparam int SL = 12;
   localparam int TO = 16;
`ifdef APB_ROUTER_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic           pclk = 1'b0;
   logic           rst;
   logic           s_psel, s_penable, s_pwrite;
   logic [AW-1:0]  s_paddr;
   logic [31:0]    s_pwdata;
   logic [3:0]     s_pstrb;
   logic           s_pready, s_pslverr;
   logic [31:0]    s_prdata;
   logic [NP-1:0]  m_psel;
   logic           m_penable, m_pwrite;
   logic [AW-1:0]  m_paddr;
   logic [31:0]    m_pwdata;
   logic [3:0]     m_pstrb;
   logic [NP-1:0]  m_pready, m_pslverr;
   logic [32*NP-1:0] m_prdata;
   logic [AW-1:0]  err_addr;

   int n_checks = 0;
   int n_fail   = 0;
   logic [AW-1:0] model_err_addr = '0;

   always #5 pclk = ~pclk;

   apb_root_router #(
      .NUM_PORTS(NP), .ADDR_WIDTH(AW), .SEL_LSB(SL), .TIMEOUT_CYCLES(TO)
   ) dut (
      .pclk(pclk), .rst(rst),
      .s_psel(s_psel), .s_penable(s_penable), .s_paddr(s_paddr),
      .s_pwrite(s_pwrite), .s_pwdata(s_pwdata), .s_pstrb(s_pstrb),
      .s_pready(s_pready), .s_prdata(s_prdata), .s_pslverr(s_pslverr),
      .m_psel(m_psel), .m_penable(m_penable), .m_paddr(m_paddr),
      .m_pwrite(m_pwrite), .m_pwdata(m_pwdata), .m_pstrb(m_pstrb),
      .m_pready(m_pready), .m_prdata(m_prdata), .m_pslverr(m_pslverr),
      .err_addr(err_addr)
   );

   task automatic test_reset();
      rst = 1'b1; s_psel = 0; s_penable = 0; s_paddr = '0; s_pwrite = 0;
      s_pwdata = '0; s_pstrb = '0; m_pready = '0; m_prdata = '0; m_pslverr = '0;
      repeat (3) @(posedge pclk);
      @(negedge pclk);
      n_checks++;
      if ({m_psel, m_penable, m_paddr, m_pwrite, m_pwdata, m_pstrb} !== '0) begin
         n_fail++;
         $display("FAIL reset_m_outputs: got psel=%b pen=%b addr=%h got nonzero, expected all 0", m_psel, m_penable, m_paddr);
      end
      n_checks++;
      if ({s_pready, s_prdata, s_pslverr, err_addr} !== '0) begin
         n_fail++;
         $display("FAIL reset_s_outputs: got pready=%b prdata=%h pslverr=%b err_addr=%h, expected all 0", s_pready, s_prdata, s_pslverr, err_addr);
      end
      rst = 1'b0;
      model_err_addr = '0;
   endtask

   // One upstream transfer against a scripted completer. Expectations come from
   // the window arithmetic: port = addr / 4096, valid only when port < NP.
   task automatic do_xfer(input logic [AW-1:0] addr, input bit wr, input logic [31:0] wd,
                          input logic [3:0] st, input int wait_n, input logic [31:0] pdata,
                          input bit perr, input bit pen_early, input string name);
      int port, exp_lat, exp_cyc, lat, psel_cyc, rises, wcnt;
      bit valid, to, done, prev;
      logic [31:0] exp_rd;
      bit exp_err;
      logic [NP-1:0] exp_sel;
      port    = int'(addr) / (1 << SL);
      valid   = port < NP;
      to      = valid && TO_EN && (wait_n >= TO);
      exp_lat = !valid ? 1 : (to ? 2 + TO : 3 + wait_n);
      exp_cyc = !valid ? 0 : (to ? 1 + TO : 2 + wait_n);
      exp_rd  = (!valid || wr || to) ? 32'h0 : pdata;
      exp_err = (!valid || to) ? 1'b1 : perr;
      exp_sel = valid ? NP'(1 << port) : '0;
      if (exp_err) model_err_addr = addr;

      m_prdata  = {$urandom, $urandom, $urandom, $urandom};
      m_pslverr = NP'($urandom);
      m_pready  = NP'($urandom);
      if (valid) begin
         m_prdata[32*port +: 32] = pdata;
         m_pslverr[port] = perr;
         m_pready[port]  = 1'b0;
      end

      if (pen_early) begin
         s_psel = 1'b0; s_penable = 1'b1; s_paddr = addr;
         @(posedge pclk); @(negedge pclk);
         n_checks++;
         if (m_psel !== '0 || s_pready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s penable_only: got psel=%b pready=%b, expected 0 and 0", name, m_psel, s_pready);
         end
      end

      s_psel = 1'b1; s_penable = 1'b1; s_paddr = addr; s_pwrite = wr; s_pwdata = wd; s_pstrb = st;
      psel_cyc = 0; rises = 0; wcnt = 0; lat = 0; done = 0; prev = 0;
      for (int n = 0; n < 200 && !done; n++) begin
         @(posedge pclk); @(negedge pclk);
         if (m_psel !== '0) begin
            n_checks++;
            if (m_psel !== exp_sel) begin
               n_fail++;
               $display("FAIL %s m_psel: got %b expected %b", name, m_psel, exp_sel);
            end
            n_checks++;
            if (m_penable !== (psel_cyc > 0)) begin
               n_fail++;
               $display("FAIL %s m_penable cycle %0d: got %b expected %b", name, psel_cyc, m_penable, psel_cyc > 0);
            end
            n_checks++;
            if (m_paddr !== addr || m_pwrite !== wr || m_pwdata !== wd || m_pstrb !== st) begin
               n_fail++;
               $display("FAIL %s m_fields: got %h/%b/%h/%b expected %h/%b/%h/%b", name,
                        m_paddr, m_pwrite, m_pwdata, m_pstrb, addr, wr, wd, st);
            end
            if (!prev) rises++;
            psel_cyc++;
         end
         prev = (m_psel !== '0);
         m_pready = NP'($urandom);
         if (valid) begin
            m_pready[port] = 1'b0;
            if (m_psel[port] && m_penable) begin
               if (wcnt == wait_n) m_pready[port] = 1'b1;
               else wcnt++;
            end
         end
         if (s_pready === 1'b1) begin
            lat  = n + 1;
            done = 1;
         end
      end
      n_checks++;
      if (!done) begin
         n_fail++;
         $display("FAIL %s no_response: got no s_pready within 200 cycles, expected latency %0d", name, exp_lat);
      end
      n_checks++;
      if (lat != exp_lat) begin
         n_fail++;
         $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
      end
      n_checks++;
      if (s_prdata !== exp_rd || s_pslverr !== exp_err) begin
         n_fail++;
         $display("FAIL %s response: got prdata=%h pslverr=%b expected %h %b", name, s_prdata, s_pslverr, exp_rd, exp_err);
      end
      n_checks++;
      if (psel_cyc != exp_cyc || (valid && rises != 1)) begin
         n_fail++;
         $display("FAIL %s psel_cycles: got %0d cycles %0d pulses expected %0d cycles 1 pulse", name, psel_cyc, rises, exp_cyc);
      end
      // Request still held across the edge where upstream sees s_pready.
      @(posedge pclk); @(negedge pclk);
      n_checks++;
      if (s_pready !== 1'b0) begin
         n_fail++;
         $display("FAIL %s pready_pulse: got %b one cycle later expected 0", name, s_pready);
      end
      s_psel = 1'b0; s_penable = 1'b0; m_pready = '0;
      @(posedge pclk); @(negedge pclk);
      n_checks++;
      if (m_psel !== '0 || s_pready !== 1'b0) begin
         n_fail++;
         $display("FAIL %s second_transfer: got psel=%b pready=%b expected 0 and 0", name, m_psel, s_pready);
      end
      n_checks++;
      if (s_prdata !== exp_rd || err_addr !== model_err_addr) begin
         n_fail++;
         $display("FAIL %s hold: got prdata=%h err_addr=%h expected %h %h", name, s_prdata, err_addr, exp_rd, model_err_addr);
      end
   endtask

   task automatic test_directed();
      do_xfer(19'h02004, 1'b0, 32'h0, 4'h0, 0, 32'hCAFEBABE, 1'b0, 1'b0, "read_p2");
      do_xfer(19'h03010, 1'b1, 32'h12345678, 4'b0011, 2, 32'hDEADBEEF, 1'b0, 1'b0, "write_p3");
      do_xfer(19'h04000, 1'b0, 32'h0, 4'h0, 0, 32'h0, 1'b0, 1'b0, "decode_err");
   endtask

   task automatic test_timeout();
      do_xfer(19'h01000, 1'b0, 32'h0, 4'h0, 40, 32'h5A5A0001, 1'b0, 1'b0, "stall_p1");
      m_pready = '1; m_pslverr = '1;
      for (int i = 0; i < 3; i++) begin
         @(posedge pclk); @(negedge pclk);
         n_checks++;
         if (s_pready !== 1'b0 || m_psel !== '0) begin
            n_fail++;
            $display("FAIL late_pready: got pready=%b psel=%b expected 0 and 0", s_pready, m_psel);
         end
      end
      m_pready = '0; m_pslverr = '0;
      do_xfer(19'h01008, 1'b0, 32'h0, 4'h0, TO - 1, 32'h600DF00D, 1'b0, 1'b0, "ready_at_terminal");
   endtask

   task automatic test_penable_early();
      do_xfer(19'h00010, 1'b0, 32'h0, 4'h0, 1, 32'h0BADCAFE, 1'b1, 1'b1, "penable_early");
   endtask

   task automatic test_reset_mid_access();
      bit seen;
      s_paddr = 19'h00100; s_pwrite = 1'b0; s_psel = 1'b1; s_penable = 1'b1; m_pready = '0;
      seen = 0;
      for (int n = 0; n < 10 && !seen; n++) begin
         @(posedge pclk); @(negedge pclk);
         if (m_penable === 1'b1) seen = 1;
      end
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("FAIL rst_mid reach_access: got no m_penable within 10 cycles, expected ACCESS");
      end
      rst = 1'b1; s_psel = 1'b0; s_penable = 1'b0;
      @(posedge pclk); #1;
      n_checks++;
      if ({m_psel, m_penable, m_paddr, s_pready, s_prdata, s_pslverr, err_addr} !== '0) begin
         n_fail++;
         $display("FAIL rst_mid outputs: got psel=%b pen=%b pready=%b err_addr=%h expected all 0", m_psel, m_penable, s_pready, err_addr);
      end
      @(negedge pclk);
      rst = 1'b0;
      model_err_addr = '0;
      for (int i = 0; i < 3; i++) begin
         @(posedge pclk); @(negedge pclk);
         n_checks++;
         if (s_pready !== 1'b0 || m_psel !== '0) begin
            n_fail++;
            $display("FAIL rst_mid no_response: got pready=%b psel=%b expected 0 and 0", s_pready, m_psel);
         end
      end
      do_xfer(19'h00040, 1'b0, 32'h0, 4'h0, 0, 32'h13579BDF, 1'b0, 1'b0, "after_reset_p0");
   endtask

   task automatic test_random();
      logic [AW-1:0] a;
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 4) == 0) a = AW'($urandom_range(NP * (1 << SL), (1 << AW) - 1));
         else a = AW'($urandom_range(0, NP * (1 << SL) - 1));
         do_xfer(a, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 3), $urandom,
                 1'($urandom), 1'($urandom), "random");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_timeout();
      test_penable_early();
      test_reset_mid_access();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
